// File: rtl/pdm_sample_sched.sv
// Sample-rate scheduler for the PDM DAC path: tick divider, tone/stream source select, gain ramps.
// Optional: define PDM_SCHED_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module pdm_sample_sched #(
  parameter int INPUT_WIDTH = 8,
  parameter int DIV_RATIO   = 1000,
  parameter int GAIN_STEP   = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play,
  input  logic                   src_sel,
  input  logic [INPUT_WIDTH-1:0] tone_data,
  output logic                   tone_ce,
  input  logic [INPUT_WIDTH-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [INPUT_WIDTH-1:0] sample,
  output logic                   sample_strobe,
  output logic [1:0]             state,
  output logic                   underrun
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [7:0]             underrun_count
`endif
);

  localparam int DW = $clog2(DIV_RATIO);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = INPUT_WIDTH + 10;
  localparam logic [INPUT_WIDTH-1:0] MID = INPUT_WIDTH'(1) << (INPUT_WIDTH - 1);
  localparam logic [8:0] UNITY = 9'd256;
  localparam logic [8:0] STEP  = 9'(GAIN_STEP);

  typedef enum logic [1:0] {
    MUTE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [8:0]             gain_q, gain_d;
  logic                   src_q, src_d;
  logic [DW-1:0]          div_cnt;
  logic                   tick, active, push, pop, starve;
  logic [INPUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_nxt;
  logic [INPUT_WIDTH-1:0] last_q, src_val, sample_d;
  logic signed [PW-1:0]   d_ext, g_ext, prod, scaled;

  assign tick      = (div_cnt == DW'(DIV_RATIO - 1));
  assign active    = (state_q != MUTE);
  assign push      = s_valid && s_ready;
  // pop looks at the pre-push occupancy, so a same-cycle push never feeds it
  assign pop       = tick && src_q && active && (count != '0);
  assign starve    = tick && src_q && active && (count == '0);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign tone_ce   = reset && tick && !src_q && active;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    src_d   = src_q;
    if (tick) begin
      case (state_q)
        MUTE: begin
          gain_d = '0;
          if (play) begin
            src_d   = src_sel;
            state_d = RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (!play) begin
            state_d = RAMP_DOWN;
          end else begin
            gain_d = (gain_q >= UNITY - STEP) ? UNITY : gain_q + STEP;
            if (gain_d == UNITY) state_d = RUN;
          end
        end
        RUN: begin
          if (!play || (src_sel != src_q)) state_d = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          gain_d = (gain_q <= STEP) ? '0 : gain_q - STEP;
          if (gain_d == '0) begin
            if (play) begin
              src_d   = src_sel;
              state_d = RAMP_UP;
            end else begin
              state_d = MUTE;
            end
          end
        end
        default: state_d = MUTE;
      endcase
    end
  end

  // The sample is scaled by the gain being entered on this tick.
  always_comb begin
    if (!src_q)   src_val = tone_data;
    else if (pop) src_val = mem[rd_ptr];
    else          src_val = last_q;
    d_ext    = $signed(PW'(src_val)) - $signed(PW'(MID));
    g_ext    = $signed(PW'(gain_d));
    prod     = d_ext * g_ext;
    scaled   = prod >>> 8;
    sample_d = INPUT_WIDTH'(scaled + $signed(PW'(MID)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt       <= '0;
      state_q       <= MUTE;
      gain_q        <= '0;
      src_q         <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      s_ready       <= 1'b0;
      last_q        <= MID;
      sample        <= MID;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      state_q <= state_d;
      gain_q  <= gain_d;
      src_q   <= src_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      count         <= count_nxt;
      s_ready       <= (count_nxt != CW'(FIFO_DEPTH));
      sample_strobe <= tick;
      underrun      <= starve;
      if (tick) sample <= sample_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= s_data;
  end

`ifdef PDM_SCHED_UNDERRUN_CNT_EN
  logic [7:0] ucnt;

  always_ff @(posedge clk) begin
    if (!reset)                              ucnt <= '0;
    else if (tick && state_q == MUTE && play) ucnt <= '0;
    else if (starve && ucnt != 8'hFF)        ucnt <= ucnt + 8'd1;
  end

  assign underrun_count = ucnt;
`endif

endmodule

// File: tb/tb_pdm_sample_sched.sv
// Bench for pdm_sample_sched: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based reference model.
module tb_pdm_sample_sched;
  localparam int W = 8, DIV = 8, STEP = 64, DEPTH = 4, MID = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b0, play = 1'b0, src_sel = 1'b0, s_valid = 1'b0;
  logic [7:0] tone_data = '0, s_data = '0;
  logic       tone_ce, s_ready, sample_strobe, underrun;
  logic [7:0] sample;
  logic [1:0] state;
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
  logic [7:0] underrun_count;
`endif

  always #5 clk = ~clk;

  pdm_sample_sched #(.INPUT_WIDTH(W), .DIV_RATIO(DIV), .GAIN_STEP(STEP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .play(play), .src_sel(src_sel), .tone_data(tone_data),
    .tone_ce(tone_ce), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sample(sample), .sample_strobe(sample_strobe), .state(state), .underrun(underrun)
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
    , .underrun_count(underrun_count)
`endif
  );

  int n_total = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // reference model: state as small integers, FIFO as a queue
  int m_div, m_state, m_gain, m_src, m_last;
  int mq[$];
  int e_sample, e_strobe, e_under, e_ready, e_ucnt;
  bit m_valid = 0;

  int cyc = 0;
  int st_cyc[$], st_sample[$], st_state[$], st_under[$];
  int ce_count = 0;

  task automatic model_step(input bit r, input bit p, input bit ss, input int td,
                            input bit sv, input int sd);
    bit tk, psh;
    int v, g, ns, nsrc;
    if (!r) begin
      m_div = 0; m_state = 0; m_gain = 0; m_src = 0; m_last = MID;
      mq.delete();
      e_sample = MID; e_strobe = 0; e_under = 0; e_ready = 0; e_ucnt = 0;
      m_valid = 1;
      return;
    end
    tk = (m_div == DIV - 1);
    psh = sv && (e_ready != 0);
    e_strobe = tk;
    e_under = 0;
    if (tk) begin
      if (m_src == 1 && m_state != 0) begin
        if (mq.size() > 0) m_last = mq.pop_front();
        else begin
          e_under = 1;
          if (e_ucnt < 255) e_ucnt++;
        end
      end
      v = (m_src == 1) ? m_last : td;
      g = m_gain; ns = m_state; nsrc = m_src;
      case (m_state)
        0: begin
          g = 0;
          if (p) begin ns = 1; nsrc = ss; e_ucnt = 0; end
        end
        1: begin
          if (!p) ns = 3;
          else begin
            g = (g + STEP > 256) ? 256 : g + STEP;
            if (g == 256) ns = 2;
          end
        end
        2: if (!p || ss != m_src) ns = 3;
        default: begin
          g = (g - STEP < 0) ? 0 : g - STEP;
          if (g == 0) begin
            if (p) begin ns = 1; nsrc = ss; end
            else ns = 0;
          end
        end
      endcase
      e_sample = MID + (((v - MID) * g) >>> 8);
      m_gain = g; m_state = ns; m_src = nsrc;
    end
    if (psh) mq.push_back(sd);
    e_ready = (mq.size() < DEPTH);
    m_div = (m_div + 1) % DIV;
  endtask

  // one clock: drive at negedge, compare against the model, advance the model
  task automatic cycle(input bit r, input bit p, input bit ss, input int td,
                       input bit sv, input int sd);
    bit exp_ce;
    @(negedge clk);
    reset = r; play = p; src_sel = ss; tone_data = 8'(td); s_valid = sv; s_data = 8'(sd);
    #1;
    cyc++;
    if (m_valid) begin
      exp_ce = r && (m_div == DIV - 1) && m_src == 0 && m_state != 0;
      chk("sample", int'(sample), e_sample);
      chk("strobe", int'(sample_strobe), e_strobe);
      chk("state", int'(state), m_state);
      chk("underrun", int'(underrun), e_under);
      chk("s_ready", int'(s_ready), e_ready);
      chk("tone_ce", int'(tone_ce), int'(exp_ce));
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
      chk("underrun_count", int'(underrun_count), e_ucnt);
`endif
    end
    if (sample_strobe === 1'b1) begin
      st_cyc.push_back(cyc);
      st_sample.push_back(int'(sample));
      st_state.push_back(int'(state));
      st_under.push_back(int'(underrun));
    end
    if (tone_ce === 1'b1) ce_count++;
    model_step(r, p, ss, td, sv, sd);
  endtask

  task automatic clear_logs();
    st_cyc.delete(); st_sample.delete(); st_state.delete(); st_under.delete();
    ce_count = 0;
  endtask

  task automatic run_strobes(input string name, input int n, input int limit,
                             input bit p, input bit ss, input int td);
    int k;
    clear_logs();
    k = 0;
    while (st_sample.size() < n && k < limit) begin
      cycle(1, p, ss, td, 0, 0);
      k++;
    end
    chk(name, st_sample.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc0, k;
    bit r, p, ss;
    int exp_up_ff[5]  = '{'h80, 'h9F, 'hBF, 'hDF, 'hFF};
    int exp_up_00[5]  = '{'h80, 'h60, 'h40, 'h20, 'h00};
    int exp_swap[10]  = '{'hFF, 'hDF, 'hBF, 'h9F, 'h80, 'h64, 'h50, 'h44, 'h40, 'h40};

    // reset release, idle
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
    chk("rst_sample", int'(sample), 'h80);
    chk("rst_ready", int'(s_ready), 0);
    clear_logs();
    cyc0 = cyc;
    repeat (25) cycle(1, 0, 0, 'h55, 0, 0);
    chk("idle_strobes", st_sample.size(), 3);
    if (st_sample.size() == 3) begin
      chk("idle_first_strobe", st_cyc[0] - cyc0, 9);
      chk("idle_period", st_cyc[2] - st_cyc[1], 8);
      chk("idle_sample", st_sample[2], 'h80);
    end
    chk("idle_tone_ce", ce_count, 0);
    chk("idle_state", int'(state), 0);

    // ramp up on tone 0x00 then 0xFF
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
    run_strobes("up00_strobes", 5, 60, 1, 0, 'h00);
    if (st_sample.size() == 5)
      for (int i = 0; i < 5; i++) chk("up00_sample", st_sample[i], exp_up_00[i]);
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
    run_strobes("upff_strobes", 5, 60, 1, 0, 'hFF);
    if (st_sample.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("upff_sample", st_sample[i], exp_up_ff[i]);
      chk("upff_state", st_state[4], 2);
    end
    chk("upff_tone_ce", ce_count, 4);

    // preload stream, switch source, drain into underrun
    for (int i = 1; i <= 4; i++) cycle(1, 1, 0, 'hFF, 1, 16 * i);
    run_strobes("swap_strobes", 10, 120, 1, 1, 'hFF);
    if (st_sample.size() == 10) begin
      for (int i = 0; i < 10; i++) chk("swap_sample", st_sample[i], exp_swap[i]);
      chk("swap_no_underrun", st_under[8], 0);
      chk("swap_underrun", st_under[9], 1);
    end
    chk("swap_tone_ce", ce_count, 5);
    chk("under_ready", int'(s_ready), 1);
`ifdef PDM_SCHED_UNDERRUN_CNT_EN
    chk("under_count", int'(underrun_count), 1);
`endif

    // FIFO full / pop / simultaneous push+pop
    for (int i = 1; i <= 4; i++) cycle(1, 1, 1, 0, 1, 'hA0 + i);
    chk("fill_ready_before", int'(s_ready), 1);
    cycle(1, 1, 1, 0, 0, 0);
    chk("fill_full", int'(s_ready), 0);
    run_strobes("pop1_strobes", 1, 20, 1, 1, 0);
    chk("pop1_ready", int'(s_ready), 1);
    chk("pop1_sample", int'(sample), 'hA1);
    run_strobes("pop2_strobes", 1, 20, 1, 1, 0);
    repeat (6) cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 1, 'hA5);
    run_strobes("pp_strobes", 1, 20, 1, 1, 0);
    chk("pp_sample", int'(sample), 'hA3);
    cycle(1, 1, 1, 0, 1, 'hA6);
    cycle(1, 1, 1, 0, 1, 'hA7);
    chk("pp_occ3_ready", int'(s_ready), 1);
    cycle(1, 1, 1, 0, 0, 0);
    chk("pp_occ4_ready", int'(s_ready), 0);

    // ramp down to gain 128, then reset mid-ramp
    run_strobes("down_strobes", 3, 40, 0, 1, 0);
    if (st_sample.size() == 3) begin
      chk("down_s0", st_sample[0], 'hA4);
      chk("down_s1", st_sample[1], 'h9B);
      chk("down_s2", st_sample[2], 'h93);
      chk("down_state", st_state[2], 3);
    end
    cycle(0, 0, 1, 0, 0, 0);
    clear_logs();
    k = 0;
    while (st_sample.size() == 0 && k < 20) begin
      cycle(1, 0, 1, 0, 0, 0);
      k++;
      if (k == 1) begin
        chk("midrst_sample", int'(sample), 'h80);
        chk("midrst_state", int'(state), 0);
        chk("midrst_ready", int'(s_ready), 0);
      end
      if (k == 2) chk("midrst_ready_rise", int'(s_ready), 1);
    end
    chk("midrst_first_strobe", k, 9);

    // random traffic against the model
    p = 1; ss = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(59) == 0) p = !p;
      if ($urandom_range(79) == 0) ss = !ss;
      r = ($urandom_range(499) != 0);
      cycle(r, p, ss, int'($urandom_range(255)), ($urandom_range(9) < 6),
            int'($urandom_range(255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
